// File: rtl/temp_sensor_pkg.sv
// Shared types and constants for the serial temperature sensor reader.
package temp_sensor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        DONE,
        GAP
    } state_t;

    localparam int DEFAULT_DATA_W = 8;

    // All-ones word: what the link returns with sdo stuck high or no sensor fitted.
    localparam logic [DEFAULT_DATA_W-1:0] FAULT_CODE = {DEFAULT_DATA_W{1'b1}};

endpackage

// File: rtl/sclk_gen.sv
// Serial clock divider: div_cnt runs 0..CLK_DIV-1 while run is high, and sclk
// toggles on each wrap. The rise/fall pulses flag the edge on which sclk changes.
module sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic sclk,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic             wrap;

    assign wrap       = run && (div_cnt == CNT_LAST);
    assign rise_pulse = wrap && !sclk;
    assign fall_pulse = wrap && sclk;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (run) begin
            if (wrap) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/temp_sensor_reader.sv
// Polls an 8-bit serial temperature sensor over cs_n/sclk/sdo and strobes each reading.
// Build option: define FAULT_DETECT_EN to reject all-ones readings and pulse sensor_fault instead.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | cs_n high, waiting for enable
// CS_SETUP | cs_n low, sclk low for CLK_DIV clocks before the first edge
// SHIFT    | sclk running, sdo sampled on each rising edge
// DONE     | one clock: reading accepted (or rejected as a fault)
// GAP      | cs_n high for SAMPLE_GAP clocks, then repeat or go idle
module temp_sensor_reader
    import temp_sensor_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int SAMPLE_GAP = 16,
    parameter int DATA_W     = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sdo,
    output logic              cs_n,
    output logic              sclk,
    output logic [DATA_W-1:0] temperature,
    output logic              sensor_valid,
    output logic              busy,
    output logic              sensor_fault
);

    localparam int TMR_MAX = (CLK_DIV > SAMPLE_GAP) ? CLK_DIV : SAMPLE_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W + 1);

    localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(SAMPLE_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD   = BIT_W'(DATA_W);

`ifdef FAULT_DETECT_EN
    localparam bit FAULT_CHECK = 1'b1;
`else
    localparam bit FAULT_CHECK = 1'b0;
`endif

    state_t            state, state_nxt;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [DATA_W-1:0] shreg;
    logic              rise_pulse, fall_pulse;
    logic              reject;
    logic              sclk_run;

    assign sclk_run = (state == SHIFT);
    assign reject   = FAULT_CHECK && (shreg == {DATA_W{FAULT_CODE[0]}});

    sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .reset      (reset),
        .run        (sclk_run),
        .clear      (!sclk_run),
        .sclk       (sclk),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        bit_nxt   = bit_cnt;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = CS_SETUP;
                    tmr_nxt   = SETUP_LOAD;
                end
            end
            CS_SETUP: begin
                if (tmr == '0) begin
                    state_nxt = SHIFT;
                    bit_nxt   = BIT_LOAD;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            SHIFT: begin
                // The last falling sclk edge closes the frame, so sclk is low on entry to DONE.
                if (fall_pulse) begin
                    bit_nxt = bit_cnt - 1'b1;
                    if (bit_cnt == BIT_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = GAP;
                tmr_nxt   = GAP_LOAD;
            end
            GAP: begin
                if (tmr == '0) begin
                    state_nxt = enable ? CS_SETUP : IDLE;
                    tmr_nxt   = SETUP_LOAD;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tmr          <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            temperature  <= '0;
            sensor_valid <= 1'b0;
            cs_n         <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmr     <= tmr_nxt;
            bit_cnt <= bit_nxt;
            if (rise_pulse) begin
                shreg <= {shreg[DATA_W-2:0], sdo};
            end
            // cs_n and busy follow the state being entered so they line up with it.
            cs_n         <= !((state_nxt == CS_SETUP) || (state_nxt == SHIFT));
            busy         <= (state_nxt != IDLE);
            sensor_valid <= (state == DONE) && !reject;
            if ((state == DONE) && !reject) begin
                temperature <= shreg;
            end
        end
    end

`ifdef FAULT_DETECT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sensor_fault <= 1'b0;
        end else begin
            sensor_fault <= (state == DONE) && reject;
        end
    end
`else
    assign sensor_fault = 1'b0;
`endif

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Directed bench for temp_sensor_reader: a behavioural sensor on the serial link,
// a table of single conversions, and hand-written multi-cycle sequences.
module tb_temp_sensor_reader;

    localparam int CLK_DIV    = 4;
    localparam int SAMPLE_GAP = 16;
    localparam int DATA_W     = 8;
    localparam int LATENCY    = 1 + CLK_DIV + 2 * DATA_W * CLK_DIV;
    localparam int PERIOD     = SAMPLE_GAP + CLK_DIV + 2 * DATA_W * CLK_DIV + 1;

    logic              clk    = 1'b0;
    logic              reset  = 1'b1;
    logic              enable = 1'b0;
    logic              sdo    = 1'b0;
    logic              cs_n, sclk, sensor_valid, busy, sensor_fault;
    logic [DATA_W-1:0] temperature;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    temp_sensor_reader #(
        .CLK_DIV    (CLK_DIV),
        .SAMPLE_GAP (SAMPLE_GAP),
        .DATA_W     (DATA_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sdo          (sdo),
        .cs_n         (cs_n),
        .sclk         (sclk),
        .temperature  (temperature),
        .sensor_valid (sensor_valid),
        .busy         (busy),
        .sensor_fault (sensor_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sensor: MSB out when cs_n falls, next bit after each falling sclk edge.
    logic [DATA_W-1:0] sensor_word = '0;
    int                bit_idx     = 0;
    logic              prev_cs     = 1'b1;
    always @(cs_n or negedge sclk) begin
        if (cs_n === 1'b0) begin
            if (prev_cs) begin
                bit_idx = DATA_W - 1;
                sdo     = sensor_word[bit_idx];
            end else if (bit_idx > 0) begin
                bit_idx = bit_idx - 1;
                sdo     = sensor_word[bit_idx];
            end
        end
        prev_cs = (cs_n !== 1'b0);
    end

    int   valid_cnt = 0, fault_cnt = 0, dbl_valid = 0, sclk_rises = 0;
    int   last_valid_cyc = 0, last_fault_cyc = 0, last_rise_cyc = 0, rise_period = 0;
    logic prev_valid = 1'b0, prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (sensor_valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            if (prev_valid) dbl_valid++;
        end
        if (sensor_fault === 1'b1) begin
            fault_cnt++;
            last_fault_cyc = cyc;
        end
        if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            sclk_rises++;
            rise_period   = cyc - last_rise_cyc;
            last_rise_cyc = cyc;
        end
        prev_valid = (sensor_valid === 1'b1);
        prev_sclk  = (sclk === 1'b1);
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) timeout_fail(name);
    endtask

    task automatic wait_event(input int v0, input int f0, input string name);
        int n = 0;
        while (valid_cnt == v0 && fault_cnt == f0 && n < 400) begin
            tick();
            n++;
        end
        if (valid_cnt == v0 && fault_cnt == f0) timeout_fail(name);
    endtask

    // Single-clock enable pulse; t is the edge on which IDLE samples it.
    task automatic pulse_enable(output int t);
        enable = 1'b1;
        t      = cyc + 1;
        tick();
        enable = 1'b0;
    endtask

    typedef struct {
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] exp_temp;
        int                exp_valid;
        int                exp_fault;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    initial begin
        int t0, v0, f0, r0, ev_cyc, v1, idle_cyc;

        vecs[0] = '{8'd20,  8'd20,  1, 0};
        vecs[1] = '{8'hA5,  8'd165, 1, 0};
        vecs[2] = '{8'd20,  8'd20,  1, 0};
`ifdef FAULT_DETECT_EN
        vecs[3] = '{8'hFF,  8'd20,  0, 1};
`else
        vecs[3] = '{8'hFF,  8'd255, 1, 0};
`endif
        vecs[4] = '{8'h00,  8'd0,   1, 0};
        vecs[5] = '{8'h80,  8'd128, 1, 0};
        vecs[6] = '{8'h01,  8'd1,   1, 0};

        // Reset held three clocks with enable low.
        reset = 1'b1;
        repeat (3) tick();
        check("reset cs_n", int'(cs_n), 1);
        check("reset sclk", int'(sclk), 0);
        check("reset temperature", int'(temperature), 0);
        check("reset sensor_valid", int'(sensor_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset sensor_fault", int'(sensor_fault), 0);
        reset = 1'b0;
        repeat (12) tick();
        check("idle busy", int'(busy), 0);
        check("idle cs_n", int'(cs_n), 1);
        check("idle sclk rises", sclk_rises, 0);

        // Single conversions from IDLE.
        for (int i = 0; i < NV; i++) begin
            v0 = valid_cnt;
            f0 = fault_cnt;
            r0 = sclk_rises;
            sensor_word = vecs[i].word;
            pulse_enable(t0);
            wait_event(v0, f0, $sformatf("vec%0d event", i));
            ev_cyc = (fault_cnt != f0) ? last_fault_cyc : last_valid_cyc;
            check($sformatf("vec%0d latency", i), ev_cyc - t0, LATENCY);
            wait_idle($sformatf("vec%0d idle", i));
            check($sformatf("vec%0d valid pulses", i), valid_cnt - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d fault pulses", i), fault_cnt - f0, vecs[i].exp_fault);
            check($sformatf("vec%0d temperature", i), int'(temperature), int'(vecs[i].exp_temp));
            check($sformatf("vec%0d sclk rises", i), sclk_rises - r0, DATA_W);
            check($sformatf("vec%0d sclk period", i), rise_period, 2 * CLK_DIV);
            check($sformatf("vec%0d cs_n idle", i), int'(cs_n), 1);
        end

        // Back-to-back conversions with enable held high.
        v0 = valid_cnt;
        sensor_word = 8'd12;
        enable = 1'b1;
        t0 = cyc + 1;
        tick();
        wait_event(v0, fault_cnt, "b2b first");
        check("b2b first latency", last_valid_cyc - t0, LATENCY);
        check("b2b first temperature", int'(temperature), 12);
        v1 = last_valid_cyc;
        sensor_word = 8'd34;
        wait_event(v0 + 1, fault_cnt, "b2b second");
        check("b2b second temperature", int'(temperature), 34);
        check("b2b period", last_valid_cyc - v1, PERIOD);
        enable = 1'b0;
        wait_idle("b2b idle");
        check("b2b valid pulses", valid_cnt - v0, 2);

        // enable dropped during bit 3 of SHIFT: the conversion still completes.
        v0 = valid_cnt;
        sensor_word = 8'd25;
        enable = 1'b1;
        t0 = cyc + 1;
        tick();
        while (cyc < t0 + 30) tick();
        check("drop busy in shift", int'(busy), 1);
        enable = 1'b0;
        wait_event(v0, fault_cnt, "drop event");
        check("drop latency", last_valid_cyc - t0, LATENCY);
        check("drop temperature", int'(temperature), 25);
        wait_idle("drop idle");
        idle_cyc = cyc;
        check("drop gap length", idle_cyc - last_valid_cyc, SAMPLE_GAP);
        repeat (30) tick();
        check("drop cs_n after", int'(cs_n), 1);
        check("drop busy after", int'(busy), 0);
        check("drop valid pulses", valid_cnt - v0, 1);

        // Reset during bit 5 after a reading of 46.
        v0 = valid_cnt;
        sensor_word = 8'd46;
        pulse_enable(t0);
        wait_event(v0, fault_cnt, "abort prior");
        wait_idle("abort prior idle");
        check("abort prior temperature", int'(temperature), 46);
        v0 = valid_cnt;
        r0 = sclk_rises;
        sensor_word = 8'h3C;
        pulse_enable(t0);
        while (cyc < t0 + 45) tick();
        check("abort cs_n before", int'(cs_n), 0);
        check("abort rises before", sclk_rises - r0, 5);
        reset = 1'b1;
        tick();
        check("abort cs_n", int'(cs_n), 1);
        check("abort sclk", int'(sclk), 0);
        check("abort temperature", int'(temperature), 0);
        check("abort busy", int'(busy), 0);
        reset = 1'b0;
        repeat (120) tick();
        check("abort no valid", valid_cnt - v0, 0);
        check("abort temperature held", int'(temperature), 0);
        check("abort stays idle", int'(busy), 0);

        check("valid never back-to-back", dbl_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
